// File: rtl/tdm_demux.sv
// TDM demultiplexer: reassembles a serial stream of per-channel samples into a
// parallel frame, aligning on frame_sync and recovering from misalignment.
module tdm_demux #(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [WIDTH-1:0]                    din,
  input  logic                                din_valid,
  input  logic                                frame_sync,
  output logic [WIDTH*CHANNELS-1:0]           ch_out,
  output logic                                frame_valid,
  output logic [((CHANNELS > 2) ? $clog2(CHANNELS) : 1)-1:0] sel_out,
  output logic                                locked,
  output logic                                sync_err
);

  localparam int SEL_W = (CHANNELS > 2) ? $clog2(CHANNELS) : 1;
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(CHANNELS - 1);
  localparam logic [SEL_W-1:0] FIRST_SEL = SEL_W'(1);

  localparam logic [0:0] HUNT   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  logic [0:0]                state;
  logic [WIDTH*CHANNELS-1:0] shadow;

  assign locked = (state == LOCKED);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  // NOTE: the shadow frame is reset along with ch_out so a frame assembled
  // right after reset never exposes power-up garbage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= HUNT;
      shadow      <= '0;
      ch_out      <= '0;
      sel_out     <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      if (din_valid) begin
        case (state)
          HUNT: begin
            if (frame_sync) begin
              shadow[0 +: WIDTH] <= din;
              sel_out            <= FIRST_SEL;
              state              <= LOCKED;
            end
          end
          default: begin
            if (frame_sync) begin
              // A sync mid-frame abandons the partial frame and restarts at slot 0.
              sync_err           <= (sel_out != '0);
              shadow[0 +: WIDTH] <= din;
              sel_out            <= FIRST_SEL;
            end else if (sel_out == '0) begin
              sync_err <= 1'b1;
              state    <= HUNT;
            end else begin
              shadow[int'(sel_out)*WIDTH +: WIDTH] <= din;
              if (sel_out == LAST_SEL) begin
                ch_out      <= {din, shadow[(CHANNELS-1)*WIDTH-1:0]};
                frame_valid <= 1'b1;
                sel_out     <= '0;
              end else begin
                sel_out <= sel_out + FIRST_SEL;
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux.sv
// Self-checking bench for tdm_demux: directed scenarios plus random traffic,
// compared every cycle against a queue-based frame model.
module tb_tdm_demux;

  localparam int W = 8;
  localparam int C = 4;
  localparam int SW = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [W-1:0]   din = '0;
  logic           din_valid = 1'b0;
  logic           frame_sync = 1'b0;
  logic [W*C-1:0] ch_out;
  logic           frame_valid;
  logic [SW-1:0]  sel_out;
  logic           locked;
  logic           sync_err;

  tdm_demux #(.WIDTH(W), .CHANNELS(C)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .frame_sync (frame_sync),
    .ch_out     (ch_out),
    .frame_valid(frame_valid),
    .sel_out    (sel_out),
    .locked     (locked),
    .sync_err   (sync_err)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  int fv_cnt = 0;
  int se_cnt = 0;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total_cnt++;
    if (actual === expected) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
  endtask

  // Reference model: collected samples of the current frame live in a queue;
  // its length is the index expected next.
  logic [W-1:0]   partial[$];
  bit             m_locked = 0;
  logic [W*C-1:0] m_ch = '0;
  bit             m_fv = 0;
  bit             m_se = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      partial.delete();
      m_locked = 0;
      m_ch     = '0;
      m_fv     = 0;
      m_se     = 0;
    end else begin
      m_fv = 0;
      m_se = 0;
      if (din_valid) begin
        if (!m_locked) begin
          if (frame_sync) begin
            partial  = '{din};
            m_locked = 1;
          end
        end else if (frame_sync) begin
          m_se    = (partial.size() != 0);
          partial = '{din};
        end else if (partial.size() == 0) begin
          m_se     = 1;
          m_locked = 0;
        end else begin
          partial.push_back(din);
          if (partial.size() == C) begin
            for (int i = 0; i < C; i++) m_ch[i*W +: W] = partial[i];
            m_fv = 1;
            partial.delete();
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    check("ch_out", 64'(ch_out), 64'(m_ch));
    check("frame_valid", 64'(frame_valid), 64'(m_fv));
    check("sync_err", 64'(sync_err), 64'(m_se));
    check("sel_out", 64'(sel_out), 64'(partial.size()));
    check("locked", 64'(locked), 64'(m_locked));
    check("fv_se_exclusive", 64'(frame_valid & sync_err), 64'd0);
    if (rst_n) begin
      fv_cnt += int'(frame_valid);
      se_cnt += int'(sync_err);
    end
  end

  // One cycle per call; inputs change just after the rising edge.
  task automatic send(input logic [W-1:0] d, input bit sync, input bit v);
    din        = d;
    frame_sync = sync;
    din_valid  = v;
    @(posedge clk);
    #1;
    din_valid  = 1'b0;
    frame_sync = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send('0, 1'b0, 1'b0);
  endtask

  int fv0, se0, gen_pos;
  bit s;

  initial begin
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Basic frame
    fv0 = fv_cnt;
    send(8'h11, 1, 1);
    check("basic_locked", 64'(locked), 64'd1);
    send(8'h22, 0, 1);
    send(8'h33, 0, 1);
    send(8'h44, 0, 1);
    check("basic_fv", 64'(frame_valid), 64'd1);
    check("basic_ch", 64'(ch_out), 64'h44332211);
    check("basic_sel", 64'(sel_out), 64'd0);
    idle(1);
    check("basic_fv_once", 64'(fv_cnt - fv0), 64'd1);

    // Asynchronous reset between edges
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_ch", 64'(ch_out), 64'd0);
    check("rst_sel", 64'(sel_out), 64'd0);
    check("rst_locked", 64'(locked), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Gaps
    fv0 = fv_cnt;
    send(8'h11, 1, 1);
    idle(2);
    check("gap_sel_hold", 64'(sel_out), 64'd1);
    send(8'h22, 0, 1);
    idle(1);
    send(8'h33, 0, 1);
    idle(3);
    check("gap_sel_hold2", 64'(sel_out), 64'd3);
    send(8'h44, 0, 1);
    check("gap_ch", 64'(ch_out), 64'h44332211);
    idle(2);
    check("gap_fv_once", 64'(fv_cnt - fv0), 64'd1);

    // Hunt: unsynchronised samples are dropped silently
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    se0 = se_cnt;
    send(8'hAA, 0, 1);
    send(8'hBB, 0, 1);
    check("hunt_unlocked", 64'(locked), 64'd0);
    send(8'h01, 1, 1);
    check("hunt_locked", 64'(locked), 64'd1);
    send(8'h02, 0, 1);
    send(8'h03, 0, 1);
    send(8'h04, 0, 1);
    check("hunt_ch", 64'(ch_out), 64'h04030201);
    idle(1);
    check("hunt_no_err", 64'(se_cnt - se0), 64'd0);

    // Early sync
    fv0 = fv_cnt;
    se0 = se_cnt;
    send(8'h11, 1, 1);
    send(8'h22, 0, 1);
    send(8'h55, 1, 1);
    check("early_err", 64'(sync_err), 64'd1);
    send(8'h66, 0, 1);
    send(8'h77, 0, 1);
    send(8'h88, 0, 1);
    check("early_ch", 64'(ch_out), 64'h88776655);
    idle(1);
    check("early_fv_once", 64'(fv_cnt - fv0), 64'd1);
    check("early_err_once", 64'(se_cnt - se0), 64'd1);

    // Missing sync
    send(8'h99, 0, 1);
    check("miss_err", 64'(sync_err), 64'd1);
    check("miss_unlocked", 64'(locked), 64'd0);
    check("miss_ch_hold", 64'(ch_out), 64'h88776655);
    send(8'h0D, 1, 1);
    send(8'h0E, 0, 1);
    send(8'h0F, 0, 1);
    send(8'h10, 0, 1);
    check("miss_ch", 64'(ch_out), 64'h100F0E0D);

    // Random traffic, mostly aligned with occasional misplaced or dropped syncs
    gen_pos = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 30) begin
        send(W'($urandom), 1'($urandom), 1'b0);
      end else begin
        s = (gen_pos == 0);
        if ($urandom_range(0, 99) < 6) s = ~s;
        send(W'($urandom), s, 1'b1);
        gen_pos = s ? 1 : (gen_pos + 1) % C;
      end
      if (i == 1500) begin
        #2;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        gen_pos = 0;
      end
    end
    idle(2);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/tdm_demux.md
# tdm_demux

Time-division demultiplexer that reassembles a serial stream of per-channel samples into a parallel frame of `CHANNELS` words. It is the receiving end of the team's mux datapath: upstream, a mux steered by a rotating select places channel 0..N-1 samples on one wire. This block tracks the same rotation and distributes each sample to its channel slot. Frame boundaries come from a sync marker, and misaligned streams are detected and recovered.

## Interface
- `WIDTH`, default 1: bits per sample (≥1).
- `CHANNELS`, default 4: channels per frame (≥2).
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `din` in `WIDTH`: incoming sample.
- `din_valid` in 1: `din` carries a sample this cycle.
- `frame_sync` in 1: sample is channel 0 of a frame; ignored when `din_valid`=0.
- `ch_out` out `WIDTH*CHANNELS`: last complete frame. Channel c is at bits [c*WIDTH +: WIDTH].
- `frame_valid` out 1: one-cycle pulse when `ch_out` has just been updated.
- `sel_out` out `max(1,$clog2(CHANNELS))`: channel index expected for the next sample.
- `locked` out 1: high in LOCKED state.
- `sync_err` out 1: one-cycle pulse on an alignment error.

## Operation
- Reset (async, `rst_n`=0) clears the state:
  - state=HUNT;
  - `ch_out`=0, shadow frame register=0;
  - `sel_out`=0;
  - `frame_valid`=0, `sync_err`=0, `locked`=0.
- Internal shadow register collects the partial frame. `ch_out` changes only on frame completion.
- States: HUNT, LOCKED.
- HUNT:
  - `din_valid`=1, `frame_sync`=0: sample discarded, no error pulse.
  - `din_valid`=1, `frame_sync`=1: write shadow[0]=`din`, `sel_out`←1, go to LOCKED.
- LOCKED, valid sample with `sel_out`=k:
  - Case k≠0, `frame_sync`=0: write shadow[k]=`din`.
    - If k=CHANNELS-1: `ch_out`←{`din`, shadow[CHANNELS-2..0]}, `frame_valid` pulses, `sel_out`←0.
    - Otherwise `sel_out`←k+1.
  - Case k=0, `frame_sync`=1: normal frame start. Write shadow[0], `sel_out`←1.
  - Case k≠0, `frame_sync`=1 (early sync): `sync_err` pulses and the partial frame is abandoned. The sample is taken as new channel 0: shadow[0]=`din`, `sel_out`←1, stay LOCKED.
  - Case k=0, `frame_sync`=0 (missing sync): `sync_err` pulses, sample discarded, `sel_out` stays 0, go to HUNT.
- `din_valid`=0: no state, index or shadow change. Gaps between samples are legal at any point in a frame.
- Abandoned partial frames never reach `ch_out`. Stale shadow slots are overwritten before the next completion.
- `sel_out` wraps CHANNELS-1 → 0 only on frame completion. It never holds a value ≥ CHANNELS.

## Timing
- All outputs are registered.
- `ch_out` and `frame_valid` update on the same edge that captures the last-channel sample. `frame_valid` is high for exactly the following cycle.
- Latency: one edge from last sample to frame visible.
- Throughput: one sample per cycle, with no bubble between frames. Back-to-back frames therefore give `frame_valid` pulses every CHANNELS cycles.
- `sync_err` is high for exactly the cycle after the offending edge.
- `frame_valid` and `sync_err` are never high in the same cycle.
- `ch_out` holds between completions, including through HUNT periods.
- Reset asserted mid-frame: all outputs clear immediately, without waiting for a clock edge. The partial frame is lost.
- First valid edge after `rst_n` rises is processed in HUNT.

## Test plan
Run with WIDTH=8, CHANNELS=4.
- Reset: drive `rst_n`=0 with `ch_out` nonzero, between edges → `ch_out`=0, `sel_out`=0, `locked`=0 immediately, with no clock edge.
- Basic frame: after reset, samples 0x11(sync), 0x22, 0x33, 0x44 on consecutive cycles → `frame_valid` for one cycle, `ch_out`=0x44332211, `sel_out`=0.
- Gaps: the same frame with `din_valid`=0 gaps of 1–3 cycles between samples → same `ch_out`. A single `frame_valid`; `sel_out` holds during gaps.
- Hunt: 0xAA, 0xBB without sync, then a valid frame 0x01(sync), 0x02, 0x03, 0x04 → no `sync_err`, `locked` rises after 0x01, `ch_out`=0x04030201.
- Early sync: 0x11(sync), 0x22, then 0x55(sync), 0x66, 0x77, 0x88 →
  - `sync_err` pulses once, on the 0x55 sample;
  - one `frame_valid`, with `ch_out`=0x88776655.
- Missing sync: after a complete frame, 0x99 with no sync → `sync_err` pulse, `locked`=0, `ch_out` unchanged. Then a frame 0x0D(sync), 0x0E, 0x0F, 0x10 → `ch_out`=0x100F0E0D.
